// File: rtl/spi_expander_gen.sv
// spi_expander_gen
// SPI (mode 0, MSB first) controlled GPIO expander. All SPI pins and the
// GPIO inputs are asynchronous to clk and are resynchronized before use; the
// SPI clock is oversampled and its edges are found by comparing the
// synchronized level with its previous-cycle value.
//
// Frame: one command byte (bit7 = 1 write / 0 read, bits[6:0] = address),
// then any number of data bytes with auto-incrementing address.
// Register map: 0..N-1 OUT_n (RW), N..2N-1 IN_n (RO), 0x7F ID (= N).
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   ss        SPI slave select, active low (async)
//   sclk      SPI clock, CPOL=0 CPHA=0 (async)
//   mosi      SPI data in (async)
//   miso      SPI data out (registered)
//   gpio_in   NUM_PORTS*8 external inputs (async), port n at [8n+7:8n]
//   gpio_out  NUM_PORTS*8 registered outputs, port n at [8n+7:8n]
//   irq       level interrupt, set on any synchronized input change
module spi_expander_gen #(
  parameter int NUM_PORTS   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ss,
  input  logic                   sclk,
  input  logic                   mosi,
  output logic                   miso,
  input  logic [NUM_PORTS*8-1:0] gpio_in,
  output logic [NUM_PORTS*8-1:0] gpio_out,
  output logic                   irq
);

  localparam int         GW        = NUM_PORTS * 8;
  localparam logic [6:0] ADDR_LAST = 7'(2 * NUM_PORTS - 1);
  localparam logic [6:0] ADDR_ID   = 7'h7F;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CMD        = 2'd1,
    DATA       = 2'd2,
    WAIT_DESEL = 2'd3
  } state_t;

  // Synchronizer chains
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [GW-1:0]          gpio_sync [SYNC_STAGES];

  logic          ss_s;
  logic          sclk_s;
  logic          mosi_s;
  logic [GW-1:0] gin_s;

  // Previous-cycle copies for edge / change detection
  logic          ss_prev;
  logic          sclk_prev;
  logic [GW-1:0] gin_prev;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_in;
  logic [7:0] shift_out;
  logic [6:0] addr;
  logic       is_write;
  logic       byte_done;   // a byte completed and its trailing sclk fall is pending

  logic       sclk_rise;
  logic       sclk_fall;
  logic       ss_fall;
  logic [7:0] byte_in;
  logic       load_now;
  logic       irq_clear;

  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign gin_s  = gpio_sync[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign ss_fall   = ~ss_s & ss_prev;
  assign byte_in   = {shift_in[6:0], mosi_s};

  // The fall after a completed byte reloads the shift-out register for reads
  assign load_now  = (state == DATA) && !is_write && byte_done && sclk_fall && !ss_s;
  assign irq_clear = load_now && is_in_addr(addr);

  function automatic logic is_in_addr(input logic [6:0] a);
    return (a >= 7'(NUM_PORTS)) && (a <= ADDR_LAST);
  endfunction

  function automatic logic [6:0] next_addr(input logic [6:0] a);
    logic [6:0] n;
    if (a == ADDR_LAST) begin
      n = 7'd0;
    end else if (a < ADDR_LAST) begin
      n = a + 7'd1;
    end else begin
      n = a;   // unmapped / ID addresses hold
    end
    return n;
  endfunction

  function automatic logic [7:0] reg_value(input logic [6:0]    a,
                                           input logic [GW-1:0] outs,
                                           input logic [GW-1:0] ins);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (a == 7'(i))             v = outs[i*8 +: 8];
      if (a == 7'(NUM_PORTS + i)) v = ins[i*8 +: 8];
    end
    if (a == ADDR_ID) v = 8'(NUM_PORTS);
    return v;
  endfunction

  // Input synchronizers
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) gpio_sync[i] <= '0;
    end else begin
      ss_sync      <= {ss_sync[SYNC_STAGES-2:0], ss};
      sclk_sync    <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync    <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      gpio_sync[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) gpio_sync[i] <= gpio_sync[i-1];
    end
  end

  // SPI protocol FSM, register file, shift registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_prev   <= 1'b0;
      sclk_prev <= 1'b0;
      gin_prev  <= '0;
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift_in  <= 8'h00;
      shift_out <= 8'h00;
      addr      <= 7'd0;
      is_write  <= 1'b0;
      byte_done <= 1'b0;
      gpio_out  <= '0;
      miso      <= 1'b0;
      irq       <= 1'b0;
    end else begin
      ss_prev   <= ss_s;
      sclk_prev <= sclk_s;
      gin_prev  <= gin_s;

      // Set has priority over clear
      if (gin_s != gin_prev) begin
        irq <= 1'b1;
      end else if (irq_clear) begin
        irq <= 1'b0;
      end

      miso <= ((state == DATA) && !is_write && !ss_s) ? shift_out[7] : 1'b0;

      case (state)
        IDLE: begin
          if (ss_fall) begin
            state     <= CMD;
            bit_cnt   <= 3'd0;
            shift_in  <= 8'h00;
            shift_out <= 8'h00;
            byte_done <= 1'b0;
          end else if (!ss_s) begin
            // ss low without a seen falling edge (e.g. out of reset):
            // the frame start was missed, wait for deselect
            state <= WAIT_DESEL;
          end
        end

        CMD, DATA: begin
          if (ss_s) begin
            // Deselect drops any partial byte
            state     <= IDLE;
            byte_done <= 1'b0;
          end else if (sclk_rise) begin
            shift_in <= byte_in;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              byte_done <= 1'b1;
              if (state == CMD) begin
                is_write <= byte_in[7];
                addr     <= byte_in[6:0];
                state    <= DATA;
              end else begin
                if (is_write) begin
                  for (int i = 0; i < NUM_PORTS; i++) begin
                    if (addr == 7'(i)) gpio_out[i*8 +: 8] <= byte_in;
                  end
                end
                addr <= next_addr(addr);
              end
            end
          end else if (sclk_fall) begin
            if (load_now) begin
              shift_out <= reg_value(addr, gpio_out, gin_s);
            end else begin
              shift_out <= {shift_out[6:0], 1'b0};
            end
            byte_done <= 1'b0;
          end
        end

        WAIT_DESEL: begin
          if (ss_s) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_expander_gen.sv
// Self-checking bench for spi_expander_gen (NUM_PORTS=2, SYNC_STAGES=2).
// A table of directed frames with constant expectations, hand-written
// sequences for write timing, abort and reset-while-selected, then random
// frames checked against a register-level model of the expander.
module tb_spi_expander_gen;

  localparam int HALF = 6;   // sclk half period in clk cycles

  logic        clk;
  logic        rst;
  logic        ss;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        irq;

  int n_chk  = 0;
  int n_pass = 0;

  spi_expander_gen #(.NUM_PORTS(2), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .ss       (ss),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  out_m [2];
  logic [15:0] gin_m;
  logic        irq_m;

  function automatic logic [7:0] m_val(input logic [6:0] a);
    if (a < 7'd2)        return out_m[a[0]];
    else if (a < 7'd4)   return gin_m[a[0]*8 +: 8];
    else if (a == 7'h7F) return 8'd2;
    else                 return 8'd0;
  endfunction

  function automatic logic [6:0] m_next(input logic [6:0] a);
    if (a == 7'd3)     return 7'd0;
    else if (a < 7'd3) return a + 7'd1;
    else               return a;
  endfunction

  // Full frame: command byte plus len-1 data bytes; every completed byte of
  // a read is followed by a load of the current address (also after the last).
  task automatic m_frame(input int len, input logic [39:0] tx, output logic [39:0] rx);
    logic [7:0] cmd;
    logic [7:0] b;
    logic [6:0] a;
    cmd = tx[39:32];
    a   = cmd[6:0];
    rx  = '0;
    for (int k = 1; k < len; k++) begin
      b = tx[39-8*k -: 8];
      if (cmd[7]) begin
        if (a < 7'd2) out_m[a[0]] = b;
      end else begin
        rx[39-8*k -: 8] = m_val(a);
        if (a >= 7'd2 && a < 7'd4) irq_m = 1'b0;
      end
      a = m_next(a);
    end
    if (!cmd[7] && a >= 7'd2 && a < 7'd4) irq_m = 1'b0;
  endtask

  function automatic logic [15:0] m_out();
    return {out_m[1], out_m[0]};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_gin(input logic [15:0] v);
    if (v != gin_m) irq_m = 1'b1;
    gin_m   = v;
    gpio_in = v;
    cyc(8);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      cyc(HALF);
      rx   = {rx[6:0], miso};
      sclk = 1'b1;
      cyc(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input int len, input logic [39:0] tx, output logic [39:0] rx);
    logic [7:0] b;
    rx = '0;
    ss = 1'b0;
    cyc(HALF);
    for (int k = 0; k < len; k++) begin
      spi_bits(tx[39-8*k -: 8], 8, b);
      rx[39-8*k -: 8] = b;
    end
    cyc(HALF);
    ss = 1'b1;
    cyc(8);
  endtask

  typedef struct {
    int          len;
    logic [39:0] tx;
    logic [15:0] gin;
    logic [15:0] exp_out;
    logic [39:0] exp_rx;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [39:0] rx_d;
    logic [39:0] rx_m;
    logic [7:0]  b;
    logic [15:0] old_out;
    logic [39:0] tx;
    logic [6:0]  a;
    int          len;

    vecs[0] = '{2, 40'h80A5000000, 16'h3C5A, 16'h00A5, 40'h0000000000, 1'b1};
    vecs[1] = '{5, 40'h8111223344, 16'h3C5A, 16'h1144, 40'h0000000000, 1'b1};
    vecs[2] = '{3, 40'h0200000000, 16'h3C5A, 16'h1144, 40'h005A3C0000, 1'b0};
    vecs[3] = '{2, 40'h7F00000000, 16'h3C5B, 16'h1144, 40'h0002000000, 1'b1};
    vecs[4] = '{2, 40'h1000000000, 16'h3C5B, 16'h1144, 40'h0000000000, 1'b1};
    vecs[5] = '{2, 40'h90FF000000, 16'h3C5B, 16'h1144, 40'h0000000000, 1'b1};
    vecs[6] = '{5, 40'h0000000000, 16'h3C5B, 16'h1144, 40'h0044115B3C, 1'b0};

    rst      = 1'b1;
    ss       = 1'b1;
    sclk     = 1'b0;
    mosi     = 1'b0;
    gpio_in  = 16'h0000;
    out_m[0] = 8'h00;
    out_m[1] = 8'h00;
    gin_m    = 16'h0000;
    irq_m    = 1'b0;

    cyc(4);
    check("reset_gpio_out", 40'(gpio_out), 40'h0);
    check("reset_miso", 40'(miso), 40'h0);
    check("reset_irq", 40'(irq), 40'h0);
    rst = 1'b0;
    cyc(6);

    // Directed table
    for (int v = 0; v < 7; v++) begin
      set_gin(vecs[v].gin);
      spi_frame(vecs[v].len, vecs[v].tx, rx_d);
      m_frame(vecs[v].len, vecs[v].tx, rx_m);
      check($sformatf("vec%0d_gpio_out", v), 40'(gpio_out), 40'(vecs[v].exp_out));
      check($sformatf("vec%0d_miso_bytes", v), rx_d, vecs[v].exp_rx);
      check($sformatf("vec%0d_irq", v), 40'(irq), 40'(vecs[v].exp_irq));
    end

    // Write latency: output changes exactly one clk after the completing rise is seen
    old_out = m_out();
    ss = 1'b0;
    cyc(HALF);
    spi_bits(8'h80, 8, b);
    spi_bits(8'hC3, 7, b);
    mosi = 1'b1;
    cyc(HALF);
    sclk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("write_latency_before", 40'(gpio_out), 40'(old_out));
    @(posedge clk);
    #1;
    check("write_latency_after", 40'(gpio_out), 40'({old_out[15:8], 8'hC3}));
    cyc(HALF);
    sclk = 1'b0;
    cyc(HALF);
    ss = 1'b1;
    cyc(8);
    m_frame(2, 40'h80C3000000, rx_m);

    // Abort after 5 bits of a write data byte
    ss = 1'b0;
    cyc(HALF);
    spi_bits(8'h80, 8, b);
    spi_bits(8'hFF, 5, b);
    cyc(2);
    ss = 1'b1;
    cyc(8);
    check("abort_no_write", 40'(gpio_out), 40'(m_out()));
    spi_frame(2, 40'h803C000000, rx_d);
    m_frame(2, 40'h803C000000, rx_m);
    check("after_abort_write", 40'(gpio_out), 40'(m_out()));

    // Random frames against the model
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 2) == 0) set_gin(16'($urandom));
      case ($urandom_range(0, 5))
        0, 1, 2, 3: a = 7'($urandom_range(0, 3));
        4:          a = 7'h7F;
        default:    a = 7'($urandom);
      endcase
      len = $urandom_range(1, 5);
      tx  = 40'({$urandom, $urandom});
      tx[39:32] = {1'($urandom), a};
      spi_frame(len, tx, rx_d);
      m_frame(len, tx, rx_m);
      if (len < 5) rx_m[39-8*len -: 8] = 8'h00;
      check($sformatf("rand%0d_gpio_out", r), 40'(gpio_out), 40'(m_out()));
      check($sformatf("rand%0d_miso_bytes", r), rx_d, rx_m);
      check($sformatf("rand%0d_irq", r), 40'(irq), 40'(irq_m));
    end

    // Reset during a data byte with ss held low
    if (gin_m == 16'h0000) set_gin(16'h00A1);
    spi_frame(3, 40'h80ABCD0000, rx_d);
    m_frame(3, 40'h80ABCD0000, rx_m);
    ss = 1'b0;
    cyc(HALF);
    spi_bits(8'h81, 8, b);
    spi_bits(8'hFF, 3, b);
    rst = 1'b1;
    cyc(2);
    check("rst_mid_gpio_out", 40'(gpio_out), 40'h0);
    check("rst_mid_miso", 40'(miso), 40'h0);
    check("rst_mid_irq", 40'(irq), 40'h0);
    cyc(2);
    rst      = 1'b0;
    out_m[0] = 8'h00;
    out_m[1] = 8'h00;
    irq_m    = (gin_m != 16'h0000);
    spi_bits(8'h80, 8, b);
    spi_bits(8'hFF, 8, b);
    cyc(HALF);
    check("rst_ignore_sclk", 40'(gpio_out), 40'h0);
    ss = 1'b1;
    cyc(8);
    check("rst_irq_resync", 40'(irq), 40'(irq_m));
    spi_frame(2, 40'h8177000000, rx_d);
    m_frame(2, 40'h8177000000, rx_m);
    check("rst_next_frame", 40'(gpio_out), 40'(m_out()));
    check("rst_next_frame_const", 40'(gpio_out), 40'h7700);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
